// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the UART TX arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        GAP
    } arb_state_t;

    // Four frame times: generous enough to ride out a slow but healthy transmitter.
    function automatic int default_timeout(input int clk_hz, input int baud, input int data_bits);
        return 4 * (clk_hz / baud) * (data_bits + 2);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side handshake bundle of the TX arbiter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int DATA_BITS = 8
);
    logic [N_REQ-1:0]           req_valid_in;
    logic [N_REQ*DATA_BITS-1:0] req_data_in;
    logic [N_REQ-1:0]           req_ready_out;
    logic                       uart_data_rdy_out;
    logic [DATA_BITS-1:0]       uart_tx_data_out;
    logic                       uart_tx_done_in;

    modport slave (
        input  req_valid_in,
        input  req_data_in,
        input  uart_tx_done_in,
        output req_ready_out,
        output uart_data_rdy_out,
        output uart_tx_data_out
    );

    modport master (
        output req_valid_in,
        output req_data_in,
        output uart_tx_done_in,
        input  req_ready_out,
        input  uart_data_rdy_out,
        input  uart_tx_data_out
    );
endinterface

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, with wrap.
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IW-1:0]    rr_ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IW-1:0]    grant_idx_o,
    output logic             any_valid_o
);

    int idx;

    // Scan from the farthest offset down so the nearest valid requester overwrites last.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_valid_o = |valid_i;
        idx         = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_i) + k) % N_REQ;
            if (valid_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N byte producers, one frame per grant.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ           = 4,
    parameter  int DATA_BITS       = 8,
    parameter  int CLOCK_FREQUENCY = 100_000_000,
    parameter  int BAUD_RATE       = 115_200,
    parameter  int GAP_CYCLES      = 0,
    parameter  int TIMEOUT_CYCLES  = default_timeout(CLOCK_FREQUENCY, BAUD_RATE, DATA_BITS),
    localparam int IW              = idx_width(N_REQ)
) (
    input  logic          clk,
    input  logic          nrst_in,
    uart_tx_arbiter_if.slave bus,
    output logic [IW-1:0] grant_id_out,
    output logic          busy_out,
    output logic          frame_done_out,
    output logic          err_timeout_out
);

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    arb_state_t           state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [WDW-1:0]       wdog_q, wdog_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic                 data_rdy_q, data_rdy_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 err_q, err_d;

    logic [N_REQ-1:0]     pick_grant;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic [DATA_BITS-1:0] req_bytes [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign req_bytes[gi] = bus.req_data_in[gi*DATA_BITS +: DATA_BITS];
    end

    uart_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .valid_i     (bus.req_valid_in),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (pick_grant),
        .grant_idx_o (pick_idx),
        .any_valid_o (pick_any)
    );

    assign bus.req_ready_out     = (state_q == IDLE) ? pick_grant : '0;
    assign bus.uart_data_rdy_out = data_rdy_q;
    assign bus.uart_tx_data_out  = data_q;
    assign grant_id_out          = grant_q;
    assign busy_out              = busy_q;
    assign frame_done_out        = frame_done_q;
    assign err_timeout_out       = err_q;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        data_d       = data_q;
        wdog_d       = wdog_q;
        gap_d        = gap_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    data_d   = req_bytes[pick_idx];
                    grant_d  = pick_idx;
                    rr_ptr_d = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = BUSY;
            end
            BUSY: begin
                // Firing on the (TIMEOUT-1)th BUSY cycle lands the pulse TIMEOUT cycles after ISSUE.
                if (bus.uart_tx_done_in) begin
                    frame_done_d = 1'b1;
                    gap_d        = '0;
                    state_d      = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else if (wdog_q == WDW'(TIMEOUT_CYCLES - 2)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        data_rdy_d = (state_d == ISSUE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            data_q       <= '0;
            wdog_q       <= '0;
            gap_q        <= '0;
            data_rdy_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            data_q       <= data_d;
            wdog_q       <= wdog_d;
            gap_q        <= gap_d;
            data_rdy_q   <= data_rdy_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two instances (no gap / 20-cycle gap) with behavioural UART stubs.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N      = 4;
    localparam int DW     = 8;
    localparam int TMO    = 100;
    localparam int GAPN   = 20;
    localparam int TX_LEN = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst;
    logic [1:0] gid_a, gid_b;
    logic busy_a, busy_b, fd_a, fd_b, err_a, err_b;
    logic stuck = 1'b0;

    uart_tx_arbiter_if #(.N_REQ(N), .DATA_BITS(DW)) bus_a ();
    uart_tx_arbiter_if #(.N_REQ(N), .DATA_BITS(DW)) bus_b ();

    uart_tx_arbiter #(.N_REQ(N), .DATA_BITS(DW), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .nrst_in(nrst), .bus(bus_a),
        .grant_id_out(gid_a), .busy_out(busy_a), .frame_done_out(fd_a), .err_timeout_out(err_a)
    );

    uart_tx_arbiter #(.N_REQ(N), .DATA_BITS(DW), .GAP_CYCLES(GAPN), .TIMEOUT_CYCLES(TMO)) dut_gap (
        .clk(clk), .nrst_in(nrst), .bus(bus_b),
        .grant_id_out(gid_b), .busy_out(busy_b), .frame_done_out(fd_b), .err_timeout_out(err_b)
    );

    // UART stubs: capture the byte on data_rdy, pulse done TX_LEN cycles later.
    int cnt_a = 0, cnt_b = 0;
    logic [7:0] rx_a[$], rx_b[$];
    always @(negedge clk) begin
        if (!nrst) begin
            cnt_a = 0; cnt_b = 0;
            bus_a.uart_tx_done_in = 1'b0;
            bus_b.uart_tx_done_in = 1'b0;
        end else begin
            bus_a.uart_tx_done_in = 1'b0;
            bus_b.uart_tx_done_in = 1'b0;
            if (cnt_a > 0) begin
                cnt_a--;
                if (cnt_a == 0 && !stuck) bus_a.uart_tx_done_in = 1'b1;
            end
            if (cnt_b > 0) begin
                cnt_b--;
                if (cnt_b == 0) bus_b.uart_tx_done_in = 1'b1;
            end
            if (bus_a.uart_data_rdy_out) begin rx_a.push_back(bus_a.uart_tx_data_out); cnt_a = TX_LEN; end
            if (bus_b.uart_data_rdy_out) begin rx_b.push_back(bus_b.uart_tx_data_out); cnt_b = TX_LEN; end
        end
    end

    int fd_cnt_a = 0;
    int viol = 0;
    always @(negedge clk) begin
        if (fd_a === 1'b1) fd_cnt_a++;
        if ($countones(bus_a.req_ready_out) > 1 || (bus_a.req_ready_out & ~bus_a.req_valid_in) != 0) viol++;
        if ($countones(bus_b.req_ready_out) > 1 || (bus_b.req_ready_out & ~bus_b.req_valid_in) != 0) viol++;
    end

    int n_cmp = 0, n_bad = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic set_req_a(input int id, input logic [7:0] b);
        bus_a.req_data_in[id*DW +: DW] = b;
        bus_a.req_valid_in[id]         = 1'b1;
    endtask

    task automatic wait_ready_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus_a.req_ready_out != 0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_fd_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (fd_a) begin ok = 1'b1; break; end
        end
    endtask

    // One grant on instance A: accept, ISSUE contents, grant id, frame completion, received byte.
    task automatic serve_a(input int id, input logic [7:0] exp_byte, input bit keep);
        bit ok;
        logic [7:0] r;
        wait_ready_a(ok);
        check("accept_seen", ok, 1);
        if (!ok) return;
        check("ready_onehot", bus_a.req_ready_out, 32'(1 << id));
        @(posedge clk); #1;
        if (!keep) bus_a.req_valid_in[id] = 1'b0;
        @(negedge clk);
        check("issue_rdy", bus_a.uart_data_rdy_out, 1);
        check("issue_data", bus_a.uart_tx_data_out, exp_byte);
        check("grant_id", gid_a, id);
        wait_fd_a(ok);
        check("frame_done", ok, 1);
        r = 'x;
        if (rx_a.size() > 0) r = rx_a.pop_front();
        check("rx_byte", r, exp_byte);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        rx_a.delete();
        rx_b.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int n, fd0;
        logic [7:0] r;
        nrst = 1'b0;
        bus_a.req_valid_in = '0; bus_a.req_data_in = '0;
        bus_b.req_valid_in = '0; bus_b.req_data_in = '0;
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_data_rdy", bus_a.uart_data_rdy_out, 0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("idle_ready", bus_a.req_ready_out, 0);
        check("idle_tx_data", bus_a.uart_tx_data_out, 0);
        check("idle_grant", gid_a, 0);
        check("idle_fd_err", {fd_a, err_a}, 0);

        // Single requester 2: same-cycle ready, one frame_done pulse.
        set_req_a(2, 8'hA5);
        #1;
        check("single_same_cycle_ready", bus_a.req_ready_out, 4'b0100);
        fd0 = fd_cnt_a;
        serve_a(2, 8'hA5, 1'b0);
        @(negedge clk);
        check("single_fd_pulse_width", fd_a, 0);
        check("single_fd_count", fd_cnt_a - fd0, 1);

        // Contention from rr_ptr=0.
        do_reset();
        set_req_a(0, 8'h10); set_req_a(1, 8'h21); set_req_a(2, 8'h32); set_req_a(3, 8'h43);
        #1;
        serve_a(0, 8'h10, 1'b0);
        serve_a(1, 8'h21, 1'b0);
        serve_a(2, 8'h32, 1'b0);
        serve_a(3, 8'h43, 1'b0);
        @(negedge clk);
        set_req_a(0, 8'h50); set_req_a(3, 8'h53);
        #1;
        serve_a(0, 8'h50, 1'b0);
        serve_a(3, 8'h53, 1'b0);

        // Rotation: 1 and 3 both held; pointer is 0 after granting 3.
        @(negedge clk);
        set_req_a(1, 8'hB1); set_req_a(3, 8'hB3);
        #1;
        serve_a(1, 8'hB1, 1'b1);
        serve_a(3, 8'hB3, 1'b1);
        serve_a(1, 8'hB1, 1'b0);
        serve_a(3, 8'hB3, 1'b0);

        // Watchdog with a transmitter that never reports done.
        @(negedge clk);
        stuck = 1'b1;
        fd0 = fd_cnt_a;
        set_req_a(0, 8'hE1);
        #1;
        wait_ready_a(ok);
        check("wdog_accept", ok, 1);
        @(posedge clk); #1;
        bus_a.req_valid_in[0] = 1'b0;
        @(negedge clk);
        check("wdog_issue", bus_a.uart_data_rdy_out, 1);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (err_a) break;
        end
        check("wdog_latency", n, TMO);
        check("wdog_idle", busy_a, 0);
        check("wdog_no_fd", fd_cnt_a - fd0, 0);
        @(negedge clk);
        check("wdog_pulse_width", err_a, 0);
        rx_a.delete();
        stuck = 1'b0;
        set_req_a(2, 8'h3C);
        #1;
        serve_a(2, 8'h3C, 1'b0);

        // Mid-frame asynchronous reset; pointer (2 after granting 1) must return to 0.
        @(negedge clk);
        set_req_a(1, 8'h5C);
        #1;
        wait_ready_a(ok);
        @(posedge clk); #1;
        bus_a.req_valid_in[1] = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_busy", busy_a, 1);
        fd0 = fd_cnt_a;
        #2;
        nrst = 1'b0;
        #1;
        check("async_rst_outputs",
              {bus_a.req_ready_out, bus_a.uart_data_rdy_out, bus_a.uart_tx_data_out, gid_a, busy_a, fd_a, err_a}, 0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        rx_a.delete();
        repeat (40) @(negedge clk);
        check("rst_no_fd", fd_cnt_a - fd0, 0);
        set_req_a(0, 8'h77); set_req_a(3, 8'h99);
        #1;
        serve_a(0, 8'h77, 1'b0);
        serve_a(3, 8'h99, 1'b0);

        // Gap instance: exactly GAPN cycles from frame_done to the next ready.
        @(negedge clk);
        bus_b.req_data_in[0*DW +: DW] = 8'h11;
        bus_b.req_data_in[1*DW +: DW] = 8'h22;
        bus_b.req_valid_in = 4'b0011;
        #1;
        check("gap_first_ready", bus_b.req_ready_out, 4'b0001);
        @(posedge clk); #1;
        bus_b.req_valid_in[0] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (fd_b) begin ok = 1'b1; break; end
        end
        check("gap_fd_seen", ok, 1);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus_b.req_ready_out != 0) break;
            @(negedge clk);
            n++;
        end
        check("gap_cycles", n, GAPN);
        check("gap_second_ready", bus_b.req_ready_out, 4'b0010);
        @(posedge clk); #1;
        bus_b.req_valid_in[1] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (fd_b) begin ok = 1'b1; break; end
        end
        check("gap_fd2_seen", ok, 1);
        check("gap_grant", gid_b, 1);
        r = 'x; if (rx_b.size() > 0) r = rx_b.pop_front();
        check("gap_rx0", r, 8'h11);
        r = 'x; if (rx_b.size() > 0) r = rx_b.pop_front();
        check("gap_rx1", r, 8'h22);
        check("gap_no_err", err_b, 0);

        check("ready_protocol", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among N independent byte producers (echo path, debug console, status reporter, ...).
- Sits between the requesters and the TX side of the `uart` module. Drives that module's `data_rdy_in` / `tx_data_in` and watches its `tx_done_out`.
- Grants are round-robin, one frame at a time, with an optional inter-frame gap and a watchdog against a stuck transmitter.

Parameters:
- N_REQ, 4, number of requesters (≥1).
- DATA_BITS, 8, byte width; must match the uart instance.
- CLOCK_FREQUENCY, 100_000_000, clk in Hz.
- BAUD_RATE, 115_200, line rate in baud.
- GAP_CYCLES, 0, idle clk cycles inserted after each completed frame.
- TIMEOUT_CYCLES, 4*(CLOCK_FREQUENCY/BAUD_RATE)*(DATA_BITS+2), watchdog limit in BUSY.

Ports:
- clk  in  1  system clock.
- nrst_in  in  1  reset; one clock, reset asynchronous, active-low.
- req_valid_in  in  N_REQ  per-requester byte-valid.
- req_data_in  in  N_REQ*DATA_BITS  packed bytes; requester i uses bits [i*DATA_BITS +: DATA_BITS].
- req_ready_out  out  N_REQ  one-hot accept; byte i is taken when valid[i] & ready[i].
- uart_data_rdy_out  out  1  to uart `data_rdy_in`.
- uart_tx_data_out  out  DATA_BITS  to uart `tx_data_in`.
- uart_tx_done_in  in  1  from uart `tx_done_out`; one-cycle pulse at end of stop bit.
- grant_id_out  out  $clog2(N_REQ) (min 1)  index of the current or last granted requester.
- busy_out  out  1  high in every state except IDLE.
- frame_done_out  out  1  one-cycle pulse per completed frame.
- err_timeout_out  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (async, nrst_in=0):
  - state=IDLE, rr_ptr=0, all outputs 0, internal data register and counters 0.
  - Mid-frame reset aborts immediately. The uart shares nrst_in, so the line returns to idle-high.
- Requester rule: once req_valid_in[i] is asserted, it stays asserted with stable data until accepted. Dropping valid early is a protocol violation and the behaviour is undefined.
- IDLE:
  - Winner g = first set bit of req_valid_in scanning rr_ptr, rr_ptr+1, ... with wrap modulo N_REQ.
  - Same cycle: req_ready_out[g]=1 (combinational from valid and state).
  - Registered: data_reg<=req_data_in[g], grant_id_out<=g, rr_ptr<=(g+1) mod N_REQ, state<=ISSUE.
  - No valid: stay in IDLE, ready=0.
- ISSUE (exactly 1 cycle):
  - uart_data_rdy_out=1, uart_tx_data_out=data_reg.
  - Watchdog cleared; state<=BUSY.
  - uart_tx_done_in is ignored in this state.
- BUSY:
  - uart_data_rdy_out=0. uart_tx_data_out holds data_reg until the state leaves BUSY.
  - Watchdog increments every cycle.
  - On uart_tx_done_in=1: frame_done_out pulses the next cycle; state<=GAP if GAP_CYCLES>0, else IDLE.
  - If the watchdog reaches TIMEOUT_CYCLES-1 with no done: err_timeout_out pulses, state<=IDLE, byte dropped (not retried).
  - Done and timeout in the same cycle: done wins.
- GAP:
  - Counts GAP_CYCLES cycles, then state<=IDLE.
  - Requests arriving during GAP wait; uart_tx_done_in is ignored.
- Latency:
  - First accept occurs in the same cycle valid is seen in IDLE.
  - uart_data_rdy_out rises 1 cycle after accept.
  - With GAP_CYCLES=0, the next accept can happen 1 cycle after the done pulse.
- Fairness: a requester holding valid continuously is served at most once per N_REQ grants when all requesters are contending.
- N_REQ=1: rr_ptr is a constant 0 and grant_id_out is tied to 0.
- Outputs except req_ready_out are registered.

Decomposition:
- Package uart_pkg:
  - arb_state_t enum {IDLE, ISSUE, BUSY, GAP}.
  - Localparam helper function for the default TIMEOUT_CYCLES.
  - Grant-index width function (max(1, $clog2(N))).
- Sub-module uart_rr_picker:
  - Combinational round-robin picker. Inputs: valid vector, rr_ptr. Outputs: one-hot grant, index, any_valid.
  - Verified standalone with exhaustive valid × pointer sweeps for N_REQ=4.

Test Plan:
- Single requester: N_REQ=4, valid[2]=1 with data 8'hA5.
  - Expect ready[2] for 1 cycle, then uart_data_rdy_out 1 cycle later.
  - Loopback rx receives 8'hA5, frame_done pulses once, grant_id=2, rr_ptr becomes 3.
- Contention: all four valid with bytes 8'h10/8'h21/8'h32/8'h43, rr_ptr=0.
  - Rx order is 10, 21, 32, 43.
  - Then reassert valid[0] and valid[3]: order is 43? No — order is 00-slot then 03-slot per pointer 0 → requester 0 then 3.
  - Check exactly one ready bit per grant.
- Rotation: valid[1] held high while valid[3] pulses per accept.
  - Grants alternate 1, 3, 1, 3; requester 1 is never served twice consecutively while 3 waits.
- Gap: GAP_CYCLES=20, two back-to-back bytes.
  - Exactly 20 cycles from frame_done_out to the next req_ready_out (±0 cycles).
- Watchdog: replace the uart with a stub that never asserts done, TIMEOUT_CYCLES=100.
  - err_timeout_out pulses 100 cycles after ISSUE, state returns to IDLE.
  - The next valid is accepted normally.
- Mid-frame reset: drop nrst_in for 3 cycles during BUSY of byte 8'h5C.
  - All outputs 0 asynchronously, rr_ptr=0, no frame_done.
  - After release, a new byte 8'h77 transmits correctly.
